serialize_word_msb_first: RTL and testbench
===========================================

# serialize_word_msb_first

Parallel-to-serial front end for the bit-sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on `serial_bit`. `serial_bit` drives the detector's `new_bit` input directly. Back-to-back words stream with no idle bubble, so multi-bit patterns spanning a word boundary (e.g. "110011") remain detectable.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-low (`rst == 0` resets on the next rising edge).
- `up_valid`  input  1  upstream word present.
- `up_ready`  output  1  block can take a word this cycle.
- `up_data`  input  WIDTH  word; sampled only on the transfer cycle (`up_valid & up_ready`).
- `serial_valid`  output  1  `serial_bit` carries a real data bit this cycle.
- `serial_bit`  output  1  current bit, MSB first; forced to 0 when `serial_valid == 0`.
- `busy`  output  1  equals `serial_valid`; kept for status/LED use.

## Operation
- State machine with two states.
  - IDLE: nothing loaded.
  - SHIFT: a word is being emitted.
- Datapath registers:
  - `shreg[WIDTH-1:0]`: `serial_bit = shreg[WIDTH-1]` when in SHIFT.
  - `cnt`, $clog2(WIDTH) bits: number of bits already emitted from the current word.
- IDLE:
  - `up_ready = 1`.
  - On transfer: `shreg <= up_data`, `cnt <= 0`, go to SHIFT.
- SHIFT, `cnt < WIDTH-1`:
  - `up_ready = 0`.
  - Each cycle: `shreg <= shreg << 1`, `cnt <= cnt + 1`.
- SHIFT, `cnt == WIDTH-1` (last bit on the output):
  - `up_ready = 1`.
  - Transfer this cycle: reload `shreg <= up_data`, `cnt <= 0`, stay in SHIFT. The new MSB follows the old LSB with no gap.
  - No transfer: go to IDLE, `shreg <= 0`.
- `up_ready` is a combinational function of state and `cnt` only. It never depends on `up_valid`.
- Upstream rules:
  - Upstream must hold `up_valid` and `up_data` stable until transfer.
  - The block never drops or duplicates a word.
- Reset (`rst == 0`), applied from any state including mid-word:
  - Go to IDLE; `shreg = 0`, `cnt = 0`.
  - Outputs after reset: `up_ready = 1`, `serial_valid = 0`, `serial_bit = 0`, `busy = 0`.
  - A partially emitted word is discarded. A transfer presented in the reset cycle is ignored.
- `cnt` never exceeds WIDTH-1. Wrap is by explicit reload, never by natural overflow, so WIDTH need not be a power of two.

## Timing
- Latency: word transferred at edge N → its MSB on `serial_bit` in cycle N+1; bit k (from MSB) in cycle N+1+k; LSB in cycle N+WIDTH.
- Throughput: one bit per clock sustained; one word per WIDTH cycles with continuous `up_valid`.
- `serial_valid` and `serial_bit` are registered outputs. No combinational path from `up_*` to them.
- Detector alignment: the detector samples `serial_bit` at the end of each cycle. For a pattern completing on the LSB of the word transferred at edge N, `detected` asserts in cycle N+WIDTH+1.
- Idle gaps put 0s into the detector. This is the required behaviour; gap zeros are part of the bit stream seen downstream.

## Structure
- Shared package `serializer_pkg`:
  - State enum `ser_state_t {SER_IDLE, SER_SHIFT}`.
  - Function `ser_cnt_w(width)` returning the counter width.
- Single module; no sub-module needed. The detector is instantiated alongside it in the top-level, not inside it.

## Test plan
- Reset then idle, WIDTH=8 → `up_ready=1`, `serial_valid=0`, `serial_bit=0` every cycle.
- Single word 8'hCC → `serial_bit` = 1,1,0,0,1,1,0,0 in cycles N+1..N+8; `up_ready` low for cycles N+1..N+7 and high in N+8; back to IDLE in N+9.
- Continuous words 8'h03 then 8'h30 with `up_valid` held → 16 contiguous valid bits 00000011_00110000; detector pulses exactly once, on the bit completing "110011" across the word boundary.
- `up_valid` asserted while shifting (cycles N+2..N+7) → no transfer until cycle N+8; `up_data` changes before N+8 are ignored.
- `rst` driven to 0 at cycle N+4 of word 8'hFF → outputs 0 from the next cycle; `up_ready=1`; remaining bits are never emitted.
- WIDTH=5, word 5'b10110 followed by an idle gap → 1,0,1,1,0 then 0s with `serial_valid=0`; `cnt` never exceeds 4.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer front end.
package serializer_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_SHIFT
  } ser_state_t;

  // Width of the bits-emitted counter; it must hold values up to width-1.
  function automatic int ser_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serialize_word_msb_first.sv
// Parallel-to-serial converter: takes WIDTH-bit words over valid/ready and emits
// them MSB first, one bit per clock, with no bubble between back-to-back words.
module serialize_word_msb_first
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             serial_valid,
  output logic             serial_bit,
  output logic             busy
);

  localparam int              CNT_W    = ser_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (state == SER_SHIFT) && (cnt == LAST_CNT);

  // Ready depends only on state and cnt, so upstream can never form a loop through it.
  assign up_ready = (state == SER_IDLE) || last_bit;

  // shreg is cleared whenever the FSM sits in IDLE, so its MSB is already 0 there.
  assign serial_valid = (state == SER_SHIFT);
  assign serial_bit   = shreg[WIDTH-1];
  assign busy         = serial_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; shreg is reset too because serial_bit is taken straight from it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SER_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        SER_IDLE: begin
          if (up_valid) begin
            shreg <= up_data;
            cnt   <= '0;
            state <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (last_bit) begin
            // Wrap by explicit reload so non-power-of-two widths never overflow cnt.
            if (up_valid) begin
              shreg <= up_data;
              cnt   <= '0;
            end else begin
              shreg <= '0;
              cnt   <= '0;
              state <= SER_IDLE;
            end
          end else begin
            shreg <= shreg << 1;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SER_IDLE;
          shreg <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serialize_word_msb_first.sv
// Directed bench for serialize_word_msb_first: table-driven vectors at WIDTH=8,
// hand sequences for word streaming, mid-word reset and a WIDTH=5 instance.
module tb_serialize_word_msb_first;

  logic       clk;
  logic       rst;
  logic       up_valid,   up_ready,   serial_valid,   serial_bit,   busy;
  logic [7:0] up_data;
  logic       up_valid_5, up_ready_5, serial_valid_5, serial_bit_5, busy_5;
  logic [4:0] up_data_5;

  int checks = 0;
  int errors = 0;

  serialize_word_msb_first #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .serial_valid(serial_valid), .serial_bit(serial_bit), .busy(busy)
  );

  serialize_word_msb_first #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid_5), .up_ready(up_ready_5), .up_data(up_data_5),
    .serial_valid(serial_valid_5), .serial_bit(serial_bit_5), .busy(busy_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [7:0] d;
    logic       exp_ready;
    logic       exp_valid;
    logic       exp_bit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic er, input logic ev, input logic eb);
    vec_t t;
    t.rst_n = r; t.v = v; t.d = d;
    t.exp_ready = er; t.exp_valid = ev; t.exp_bit = eb;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [15:0] stream;
    logic [5:0]  win;
    logic [7:0]  words [2];
    logic [4:0]  w5;
    int          nbits, first_cyc, last_cyc, hits, idx;
    logic        xfer;

    rst = 1'b0; up_valid = 1'b0; up_data = '0;
    up_valid_5 = 1'b0; up_data_5 = '0;

    // Reset, then idle.
    for (int i = 0; i < 2; i++) add(0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 1, 0, 0);
    // Single word 8'hCC.
    add(1, 1, 8'hCC, 0, 1, 1);
    add(1, 0, 8'h00, 0, 1, 1);
    add(1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 8'h00, 0, 1, 1);
    add(1, 0, 8'h00, 0, 1, 1);
    add(1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 8'h00, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0);
    // 8'hA5 with up_valid held and junk data while shifting; 8'h81 follows.
    add(1, 1, 8'hA5, 0, 1, 1);
    add(1, 1, 8'h00, 0, 1, 0);
    add(1, 1, 8'hFF, 0, 1, 1);
    add(1, 1, 8'h3C, 0, 1, 0);
    add(1, 1, 8'h00, 0, 1, 0);
    add(1, 1, 8'hFF, 0, 1, 1);
    add(1, 1, 8'h12, 0, 1, 0);
    add(1, 1, 8'h34, 1, 1, 1);
    add(1, 1, 8'h81, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 8'h00, 1, 1, 1);
    add(1, 0, 8'h00, 1, 0, 0);

    foreach (vecs[i]) begin
      rst      = vecs[i].rst_n;
      up_valid = vecs[i].v;
      up_data  = vecs[i].d;
      tick();
      check($sformatf("vec%0d up_ready", i),     {31'd0, up_ready},     {31'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d serial_valid", i), {31'd0, serial_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d serial_bit", i),   {31'd0, serial_bit},   {31'd0, vecs[i].exp_bit});
      check($sformatf("vec%0d busy", i),         {31'd0, busy},         {31'd0, vecs[i].exp_valid});
    end
    up_valid = 1'b0;
    tick();

    // Back-to-back 8'h03, 8'h30: contiguous stream, one "110011" across the boundary.
    words[0] = 8'h03; words[1] = 8'h30;
    idx = 0; nbits = 0; first_cyc = -1; last_cyc = -1; hits = 0; stream = '0; win = '0;
    up_valid = 1'b1; up_data = words[0];
    for (int cyc = 0; cyc < 24; cyc++) begin
      xfer = up_valid && up_ready;
      tick();
      if (xfer) begin
        idx++;
        if (idx < 2) up_data = words[idx];
        else up_valid = 1'b0;
      end
      win = {win[4:0], serial_bit};
      if (win == 6'b110011) hits++;
      if (serial_valid) begin
        stream = {stream[14:0], serial_bit};
        nbits++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    up_valid = 1'b0;
    check("stream words taken", idx, 2);
    check("stream bit count", nbits, 16);
    check("stream contiguous", last_cyc - first_cyc + 1, 16);
    check("stream bits", {16'd0, stream}, 32'h0000_0330);
    check("stream pattern hits", hits, 1);

    // Reset in cycle N+4 of 8'hFF, with a transfer offered in the reset cycle.
    up_valid = 1'b1; up_data = 8'hFF;
    tick();
    up_valid = 1'b0;
    tick(); tick(); tick();
    check("pre-reset serial_bit", {31'd0, serial_bit}, 32'd1);
    rst = 1'b0; up_valid = 1'b1; up_data = 8'hFF;
    tick();
    rst = 1'b1; up_valid = 1'b0;
    check("post-reset up_ready", {31'd0, up_ready}, 32'd1);
    check("post-reset serial_valid", {31'd0, serial_valid}, 32'd0);
    check("post-reset serial_bit", {31'd0, serial_bit}, 32'd0);
    check("post-reset busy", {31'd0, busy}, 32'd0);
    nbits = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (serial_valid || serial_bit) nbits++;
    end
    check("post-reset no leftover bits", nbits, 0);

    // WIDTH=5: 5'b10110 then idle gap.
    w5 = 5'b10110;
    up_valid_5 = 1'b1; up_data_5 = w5;
    tick();
    up_valid_5 = 1'b0; up_data_5 = '0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("w5 bit%0d valid", k), {31'd0, serial_valid_5}, 32'd1);
      check($sformatf("w5 bit%0d", k), {31'd0, serial_bit_5}, {31'd0, w5[4-k]});
      check($sformatf("w5 bit%0d up_ready", k), {31'd0, up_ready_5}, (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("w5 bit%0d cnt", k), {29'd0, dut5.cnt}, k);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("w5 gap%0d valid", k), {31'd0, serial_valid_5}, 32'd0);
      check($sformatf("w5 gap%0d bit", k), {31'd0, serial_bit_5}, 32'd0);
      check($sformatf("w5 gap%0d up_ready", k), {31'd0, up_ready_5}, 32'd1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
